// File: rtl/hvac_load_arbiter_pkg.sv
// hvac_load_pkg: shared load indices, zone mapping and load state encoding for HVAC power arbitration
package hvac_load_pkg;
  localparam int NUM_LOADS = 4;
  localparam int NUM_ZONES = 2;
  localparam int LD_AC1 = 0;
  localparam int LD_AC2 = 1;
  localparam int LD_HT1 = 2;
  localparam int LD_HT2 = 3;
  typedef enum logic [1:0] {LOCK, IDLE, ON} load_state_t;
  function automatic int zone_of(input int ld);
    return ld % NUM_ZONES;
  endfunction
  function automatic bit is_heat(input int ld);
    return ld >= LD_HT1;
  endfunction
  function automatic int ac_of_zone(input int z);
    return z == 0 ? LD_AC1 : LD_AC2;
  endfunction
endpackage

// File: rtl/hvac_load_arbiter_if.sv
// hvac_load_arbiter_if: request/shed inputs and relay/status outputs between master control and the arbiter
interface hvac_load_arbiter_if;
  import hvac_load_pkg::*;
  logic [NUM_LOADS-1:0] req;
  logic [NUM_ZONES-1:0] shed;
  logic [NUM_LOADS-1:0] grant;
  logic [NUM_LOADS-1:0] lockout;
  logic busy;
  modport master(output req, shed, input grant, lockout, busy);
  modport slave(input req, shed, output grant, lockout, busy);
endinterface

// File: rtl/hvac_load_arbiter_second_tick.sv
// second_tick: CLK_HZ prescaler producing a one-clock pulse once per second
module second_tick #(
  parameter int CLK_HZ = 33_000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);
  localparam int W = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(CLK_HZ - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/hvac_load_arbiter.sv
// hvac_load_arbiter: shares limited coach power between four HVAC loads with min-off, stagger, cap and shed
module hvac_load_arbiter
  import hvac_load_pkg::*;
#(
  parameter int CLK_HZ    = 33_000,
  parameter int MIN_OFF_S = 180,
  parameter int STAGGER_S = 5,
  parameter int MAX_LOADS = 2
) (
  input logic clock,
  input logic reset,
  hvac_load_arbiter_if.slave bus
);
  localparam int CW = MIN_OFF_S > 0 ? $clog2(MIN_OFF_S + 1) : 1;
  localparam int SW = STAGGER_S > 0 ? $clog2(STAGGER_S + 1) : 1;
  localparam int PW = $clog2(NUM_LOADS);
  logic tick;
  logic [NUM_LOADS-1:0] elig, leave, on, lock, sel;
  logic [PW-1:0] ptr, ptr_nx, idx;
  logic [SW-1:0] stag, stag_nx;
  logic found, room;
  int active;
  second_tick #(.CLK_HZ(CLK_HZ)) u_tick (.clock(clock), .reset(reset), .tick(tick));
  for (genvar i = 0; i < NUM_LOADS; i++) begin : g_load
    localparam bit HEAT = is_heat(i);
    localparam int AC = ac_of_zone(zone_of(i));
    load_state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic drop;
    // a heater yields to its zone's AC whenever that AC is requested
    assign drop = !bus.req[i] || bus.shed[zone_of(i)] || (HEAT && bus.req[AC]);
    assign elig[i] = state == IDLE && !drop;
    assign leave[i] = state == ON && drop;
    assign on[i] = state == ON;
    assign lock[i] = state == LOCK;
    always_ff @(posedge clock or posedge reset)
      if (reset) begin
        state <= LOCK;
        cnt <= CW'(MIN_OFF_S);
      end else begin
        state <= state_nx;
        cnt <= cnt_nx;
      end
    always_comb begin
      state_nx = state;
      cnt_nx = cnt;
      unique case (state)
        LOCK: begin
          state_nx = (cnt == '0 || (tick && cnt == CW'(1))) ? IDLE : LOCK;
          cnt_nx = (tick && cnt != '0) ? cnt - CW'(1) : cnt;
        end
        IDLE: state_nx = sel[i] ? ON : IDLE;
        ON: begin
          state_nx = leave[i] ? LOCK : ON;
          cnt_nx = leave[i] ? CW'(MIN_OFF_S) : cnt;
        end
        default: state_nx = LOCK;
      endcase
    end
  end
  // loads leaving this cycle free their slot for a same-cycle grant
  assign active = int'($countones(on)) - int'($countones(leave));
  assign room = stag == '0 && active < MAX_LOADS;
  always_comb begin
    sel = '0;
    found = 1'b0;
    idx = '0;
    ptr_nx = ptr;
    for (int k = 0; k < NUM_LOADS; k++) begin
      idx = ptr + PW'(k);
      if (room && !found && elig[idx]) begin
        sel[idx] = 1'b1;
        found = 1'b1;
        ptr_nx = idx + PW'(1);
      end
    end
    stag_nx = found ? SW'(STAGGER_S) : (tick && stag != '0) ? stag - SW'(1) : stag;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      ptr <= '0;
      stag <= '0;
    end else begin
      ptr <= ptr_nx;
      stag <= stag_nx;
    end
  assign bus.grant = on;
  assign bus.lockout = lock;
  assign bus.busy = stag != '0;
endmodule
